// File: rtl/gpu_axi_pkg.sv
// gpu_axi_pkg: shared AXI response codes, FSM state types and GPU register offsets
package gpu_axi_pkg;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} rd_state_t;
  localparam logic [11:0] GPU_REG_CTRL       = 12'h000;
  localparam logic [11:0] GPU_REG_STATUS     = 12'h004;
  localparam logic [11:0] GPU_REG_RESOLUTION = 12'h008;
  localparam logic [11:0] GPU_REG_CMD        = 12'h104;
endpackage

// File: rtl/gpu_axi_watchdog.sv
// gpu_axi_watchdog: cycle counter (clk, rst, clear, run) raising expired on the TIMEOUT_CYCLES-th run cycle
module gpu_axi_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : run ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired = run && cnt_q == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/axi4_lite_gpu_slave.sv
// axi4_lite_gpu_slave: AXI4-Lite slave (s_axi_* channels) driving start/done write and read requests to the GPU decoder
module axi4_lite_gpu_slave
  import gpu_axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    write_processing_start,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    write_processing_ok,
  input  logic                    write_processing_done,
  output logic                    read_processing_start,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    read_resp_ok,
  input  logic                    read_processing_done
);
  wr_state_t w_state_q, w_state_d;
  rd_state_t r_state_q, r_state_d;
  logic aw_got_q, aw_got_d, w_got_q, w_got_d, strb_ok_q, strb_ok_d;
  logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  resp_t bresp_q, bresp_d, rresp_q, rresp_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic aw_hs, w_hs, ar_hs, w_expired, r_expired;
  assign aw_hs = awready_q && s_axi_awvalid;
  assign w_hs  = wready_q && s_axi_wvalid;
  assign ar_hs = arready_q && s_axi_arvalid;
  gpu_axi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog_w (
    .clk(clk), .rst(rst), .clear(w_state_q != W_EXEC), .run(w_state_q == W_EXEC), .expired(w_expired)
  );
  gpu_axi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog_r (
    .clk(clk), .rst(rst), .clear(r_state_q != R_EXEC), .run(r_state_q == R_EXEC), .expired(r_expired)
  );
  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    aw_got_d  = aw_got_q | aw_hs;
    w_got_d   = w_got_q | w_hs;
    strb_ok_d = w_hs ? &s_axi_wstrb : strb_ok_q;
    waddr_d   = aw_hs ? s_axi_awaddr : waddr_q;
    wdata_d   = w_hs ? s_axi_wdata : wdata_q;
    case (w_state_q)
      W_IDLE: if (aw_got_d && w_got_d) begin
        w_state_d = strb_ok_d ? W_EXEC : W_RESP;
        bresp_d   = strb_ok_d ? bresp_q : RESP_SLVERR;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
      end
      W_EXEC: if (write_processing_done || w_expired) begin
        w_state_d = W_RESP;
        bresp_d   = (write_processing_done && write_processing_ok) ? RESP_OKAY : RESP_SLVERR;
      end
      W_RESP: w_state_d = s_axi_bready ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = w_state_d == W_IDLE && !aw_got_d;
    wready_d  = w_state_d == W_IDLE && !w_got_d;
  end
  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    raddr_d   = ar_hs ? s_axi_araddr : raddr_q;
    case (r_state_q)
      R_IDLE: r_state_d = ar_hs ? R_EXEC : R_IDLE;
      R_EXEC: if (read_processing_done || r_expired) begin
        r_state_d = R_RESP;
        rdata_d   = read_processing_done ? read_data : '0;
        rresp_d   = (read_processing_done && read_resp_ok) ? RESP_OKAY : RESP_SLVERR;
      end
      R_RESP: r_state_d = s_axi_rready ? R_IDLE : R_RESP;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = r_state_d == R_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      strb_ok_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      strb_ok_q <= strb_ok_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
    end
  end
  assign s_axi_awready          = awready_q;
  assign s_axi_wready           = wready_q;
  assign s_axi_arready          = arready_q;
  assign s_axi_bvalid           = w_state_q == W_RESP;
  assign s_axi_bresp            = bresp_q;
  assign s_axi_rvalid           = r_state_q == R_RESP;
  assign s_axi_rresp            = rresp_q;
  assign s_axi_rdata            = rdata_q;
  assign write_processing_start = w_state_q == W_EXEC;
  assign write_address          = waddr_q;
  assign write_data             = wdata_q;
  assign read_processing_start  = r_state_q == R_EXEC;
  assign read_address           = raddr_q;
endmodule

// File: tb/tb_axi4_lite_gpu_slave.sv
// tb_axi4_lite_gpu_slave: directed scoreboard bench for axi4_lite_gpu_slave with a behavioural GPU decoder
module tb_axi4_lite_gpu_slave;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [11:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b1, s_axi_arvalid = 1'b0, s_axi_rready = 1'b1;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, write_data, read_data;
  logic [11:0] write_address, read_address;
  logic write_processing_start, write_processing_ok, write_processing_done;
  logic read_processing_start, read_resp_ok, read_processing_done;
  logic wr_hang = 1'b0, wr_ok_ctl = 1'b1, rd_hang = 1'b0;
  axi4_lite_gpu_slave #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .write_processing_start(write_processing_start), .write_address(write_address), .write_data(write_data),
    .write_processing_ok(write_processing_ok), .write_processing_done(write_processing_done),
    .read_processing_start(read_processing_start), .read_address(read_address), .read_data(read_data),
    .read_resp_ok(read_resp_ok), .read_processing_done(read_processing_done)
  );
  // decoder model: combinational write done, registered read done one cycle after start
  assign write_processing_done = write_processing_start & ~wr_hang;
  assign write_processing_ok   = wr_ok_ctl;
  always @(posedge clk) begin
    read_processing_done <= !rst && read_processing_start && !rd_hang;
    read_resp_ok         <= read_address == 12'h008;
    read_data            <= read_address == 12'h008 ? 32'h01E0_0280 : 32'hBAD0_0BAD;
  end
  int wr_start_cyc = 0, rd_start_cyc = 0;
  always @(posedge clk) begin
    if (write_processing_start) wr_start_cyc <= wr_start_cyc + 1;
    if (read_processing_start) rd_start_cyc <= rd_start_cyc + 1;
  end
  logic [1:0]  wq[$];
  logic [33:0] rq[$];
  int vectors = 0, miscompares = 0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] outs();
    return 128'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready, s_axi_rvalid,
                 s_axi_rresp, s_axi_rdata, write_processing_start, write_address, write_data,
                 read_processing_start, read_address});
  endfunction
  task automatic wait_b(input string tag, output int lat);
    logic seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = s_axi_bvalid;
      lat = i + 1;
      if (!seen) step();
    end
    chk({tag, "_bvalid"}, 128'(seen), 128'(1));
    if (seen) begin
      if (wq.size() == 0) chk({tag, "_b_extra"}, 128'(s_axi_bvalid), 128'(0));
      else chk({tag, "_bresp"}, 128'(s_axi_bresp), 128'(wq.pop_front()));
      step();
    end
  endtask
  task automatic wait_r(input string tag, output int lat);
    logic seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = s_axi_rvalid;
      lat = i + 1;
      if (!seen) step();
    end
    chk({tag, "_rvalid"}, 128'(seen), 128'(1));
    if (seen) begin
      if (rq.size() == 0) chk({tag, "_r_extra"}, 128'(s_axi_rvalid), 128'(0));
      else chk({tag, "_rresp_rdata"}, 128'({s_axi_rresp, s_axi_rdata}), 128'(rq.pop_front()));
      step();
    end
  endtask
  task automatic do_write(input string tag, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, input int elat, input int estarts);
    int c0, lat;
    c0 = wr_start_cyc;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    wq.push_back(er);
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    wait_b(tag, lat);
    chk({tag, "_latency"}, 128'(lat), 128'(elat));
    chk({tag, "_starts"}, 128'(wr_start_cyc - c0), 128'(estarts));
  endtask
  task automatic do_read(input string tag, input logic [11:0] a, input logic [1:0] er, input logic [31:0] ed,
                         input int elat, input int estarts);
    int c0, lat;
    c0 = rd_start_cyc;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    rq.push_back({er, ed});
    step();
    s_axi_arvalid = 1'b0;
    wait_r(tag, lat);
    chk({tag, "_latency"}, 128'(lat), 128'(elat));
    chk({tag, "_starts"}, 128'(rd_start_cyc - c0), 128'(estarts));
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
  initial begin
    int c0, lat;
    step(); step();
    @(negedge clk) chk("rst_hold_outs", outs(), 128'(0));
    step();
    rst = 1'b0;
    @(negedge clk) chk("rst_after_outs", outs(), 128'(0));
    step();
    @(negedge clk) chk("idle_readys", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'(3'b111));
    do_write("wr_together", 12'h104, 32'h0010_0020, 4'hF, 2'b00, 2, 1);
    chk("wr_together_data", 128'({write_address, write_data}), 128'({12'h104, 32'h0010_0020}));
    c0 = wr_start_cyc;
    s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    step();
    s_axi_wvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_wready_low", 128'({s_axi_wready, s_axi_awready, write_processing_start}), 128'(3'b010));
    step();
    @(negedge clk) chk("wfirst_no_start1", 128'(write_processing_start), 128'(0));
    step();
    s_axi_awaddr = 12'h000; s_axi_awvalid = 1'b1;
    wq.push_back(2'b00);
    @(negedge clk) chk("wfirst_no_start2", 128'(write_processing_start), 128'(0));
    step();
    s_axi_awvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_start_payload", 128'({write_processing_start, write_address, write_data}), 128'({1'b1, 12'h000, 32'hDEAD_BEEF}));
    wait_b("wfirst", lat);
    chk("wfirst_latency", 128'(lat), 128'(1));
    chk("wfirst_starts", 128'(wr_start_cyc - c0), 128'(1));
    do_write("wr_badstrb", 12'h004, 32'h1234_5678, 4'b0111, 2'b10, 1, 0);
    wr_ok_ctl = 1'b0;
    do_write("wr_nok", 12'h0FC, 32'h0000_0001, 4'hF, 2'b10, 2, 1);
    wr_ok_ctl = 1'b1;
    do_read("rd_hit", 12'h008, 2'b00, 32'h01E0_0280, 3, 2);
    do_read("rd_miss", 12'h0FC, 2'b10, 32'hBAD0_0BAD, 3, 2);
    rd_hang = 1'b1;
    do_read("rd_timeout", 12'h008, 2'b10, 32'h0, 17, 16);
    rd_hang = 1'b0;
    do_read("rd_after_to", 12'h008, 2'b00, 32'h01E0_0280, 3, 2);
    wr_hang = 1'b1;
    do_write("wr_timeout", 12'h104, 32'h5555_AAAA, 4'hF, 2'b10, 17, 16);
    wr_hang = 1'b0;
    do_write("wr_after_to", 12'h104, 32'h0BAD_F00D, 4'hF, 2'b00, 2, 1);
    s_axi_rready = 1'b0;
    s_axi_awaddr = 12'h104; s_axi_wdata = 32'hCAFE_0001; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 12'h008; s_axi_arvalid = 1'b1;
    wq.push_back(2'b00);
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    wait_b("conc_wr", lat);
    chk("conc_wr_latency", 128'(lat), 128'(2));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid_payload", 128'({s_axi_rvalid, s_axi_rresp, s_axi_rdata}), 128'({1'b1, 2'b00, 32'h01E0_0280}));
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk) chk("midrst_outs", outs(), 128'(0));
    step();
    @(negedge clk);
    chk("midrst_idle", 128'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}), 128'(5'b11100));
    s_axi_rready = 1'b1;
    do_read("rd_after_rst", 12'h0FC, 2'b10, 32'hBAD0_0BAD, 3, 2);
    chk("wq_drained", 128'(wq.size()), 128'(0));
    chk("rq_drained", 128'(rq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
